// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register file write port between the ALU and
// load writeback paths, and tracks pending writes in a per-register scoreboard.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   stall                            blocks all grants this cycle
//   alu_valid/addr/data, alu_ready   ALU writeback handshake
//   mem_valid/addr/data, mem_ready   load writeback handshake
//   claim_valid/addr                 issue stage reserves a destination
//   we, wa, wd                       registered register file write port
//   busy                             registered pending-write bitmask
module reg_wb_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         alu_valid,
    input  logic [ADDR_WIDTH-1:0]        alu_addr,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_ready,
    input  logic                         claim_valid,
    input  logic [ADDR_WIDTH-1:0]        claim_addr,
    output logic                         we,
    output logic [ADDR_WIDTH-1:0]        wa,
    output logic [DATA_WIDTH-1:0]        wd,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy
);

    localparam int NREG = 1 << ADDR_WIDTH;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    gnt_e                  last_grant;
    logic                  alu_fire;
    logic                  mem_fire;
    logic                  any_fire;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [NREG-1:0]       busy_next;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        alu_ready = !stall && alu_valid &&
                    (!mem_valid || last_grant == GNT_MEM);
        mem_ready = !stall && mem_valid &&
                    (!alu_valid || last_grant == GNT_ALU);
    end

    assign alu_fire = alu_valid && alu_ready;
    assign mem_fire = mem_valid && mem_ready;
    assign any_fire = alu_fire || mem_fire;

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        unique case (1'b1)
            alu_fire: begin
                gnt_addr = alu_addr;
                gnt_data = alu_data;
            end
            mem_fire: begin
                gnt_addr = mem_addr;
                gnt_data = mem_data;
            end
            default: ;
        endcase
    end

    // Clear first, then set: a new claim on the register being written
    // belongs to a younger producer and must survive.
    always_comb begin
        busy_next = busy;
        if (any_fire)
            busy_next[gnt_addr] = 1'b0;
        if (claim_valid)
            busy_next[claim_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            busy       <= '0;
            last_grant <= GNT_MEM;
        end else begin
            busy <= busy_next;
            if (any_fire) begin
                we         <= 1'b1;
                wa         <= gnt_addr;
                wd         <= gnt_data;
                last_grant <= alu_fire ? GNT_ALU : GNT_MEM;
            end else begin
                we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed, table-driven bench for reg_wb_arbiter
// with a hand-written mid-transaction reset sequence.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        claim_valid;
    logic [3:0]  claim_addr;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [15:0] busy;

    int n_cmp;
    int n_err;

    reg_wb_arbiter #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .alu_valid(alu_valid),
        .alu_addr(alu_addr),
        .alu_data(alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .claim_valid(claim_valid),
        .claim_addr(claim_addr),
        .we(we),
        .wa(wa),
        .wd(wd),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [3:0]  ma;
        logic [31:0] md;
        logic        cv;
        logic [3:0]  ca;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;
        logic [15:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic rst, logic st,
        logic av, logic [3:0] aa, logic [31:0] ad,
        logic mv, logic [3:0] ma, logic [31:0] md,
        logic cv, logic [3:0] ca,
        logic ear, logic emr, logic ewe,
        logic [3:0] ewa, logic [31:0] ewd, logic [15:0] eb
    );
        vec_t v;
        v.rst = rst;  v.stall = st;
        v.av = av;    v.aa = aa;    v.ad = ad;
        v.mv = mv;    v.ma = ma;    v.md = md;
        v.cv = cv;    v.ca = ca;
        v.e_ar = ear; v.e_mr = emr; v.e_we = ewe;
        v.e_wa = ewa; v.e_wd = ewd; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act,
                       logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h want %h",
                     name, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        alu_valid   = 1'b0;
        alu_addr    = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_data    = '0;
        claim_valid = 1'b0;
        claim_addr  = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        n_cmp = 0;
        n_err = 0;

        // r: rst st | av aa ad | mv ma md | cv ca | ar mr we wa wd busy
        // Basic write after reset
        vecs.push_back(mk(1,0, 1,3,32'hDEADBEEF, 0,0,0, 0,0,
                          1,0, 1,3,32'hDEADBEEF, 16'h0000));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,
                          0,0, 0,3,32'hDEADBEEF, 16'h0000));
        // Tie round-robin: ALU, MEM, ALU, MEM
        vecs.push_back(mk(1,0, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          1,0, 1,1,32'hA1, 16'h0000));
        vecs.push_back(mk(0,0, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          0,1, 1,2,32'hB2, 16'h0000));
        vecs.push_back(mk(0,0, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          1,0, 1,1,32'hA1, 16'h0000));
        vecs.push_back(mk(0,0, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          0,1, 1,2,32'hB2, 16'h0000));
        // Stall three cycles, then ALU wins
        vecs.push_back(mk(1,1, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          0,0, 0,0,32'h0, 16'h0000));
        vecs.push_back(mk(0,1, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          0,0, 0,0,32'h0, 16'h0000));
        vecs.push_back(mk(0,1, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          0,0, 0,0,32'h0, 16'h0000));
        vecs.push_back(mk(0,0, 1,1,32'hA1, 1,2,32'hB2, 0,0,
                          1,0, 1,1,32'hA1, 16'h0000));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,
                          0,0, 0,1,32'hA1, 16'h0000));
        // Scoreboard claim / clear
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 1,5,
                          0,0, 0,1,32'hA1, 16'h0020));
        vecs.push_back(mk(0,0, 0,0,0, 1,5,32'h55, 0,0,
                          0,1, 1,5,32'h55, 16'h0000));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 1,5,
                          0,0, 0,5,32'h55, 16'h0020));
        vecs.push_back(mk(0,0, 0,0,0, 1,5,32'h66, 1,7,
                          0,1, 1,5,32'h66, 16'h0080));
        // Set wins over clear on same register
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 1,4,
                          0,0, 0,5,32'h66, 16'h0090));
        vecs.push_back(mk(0,0, 1,4,32'h44, 0,0,0, 1,4,
                          1,0, 1,4,32'h44, 16'h0090));
        // Unclaimed write
        vecs.push_back(mk(1,0, 0,0,0, 1,9,32'h99, 0,0,
                          0,1, 1,9,32'h99, 16'h0000));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,
                          0,0, 0,9,32'h99, 16'h0000));

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_we", -1, 32'(we), 32'h0);
        chk("rst_wa", -1, 32'(wa), 32'h0);
        chk("rst_wd", -1, wd, 32'h0);
        chk("rst_busy", -1, 32'(busy), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            stall       = vecs[i].stall;
            alu_valid   = vecs[i].av;
            alu_addr    = vecs[i].aa;
            alu_data    = vecs[i].ad;
            mem_valid   = vecs[i].mv;
            mem_addr    = vecs[i].ma;
            mem_data    = vecs[i].md;
            claim_valid = vecs[i].cv;
            claim_addr  = vecs[i].ca;
            #1;
            chk("alu_ready", i, 32'(alu_ready), 32'(vecs[i].e_ar));
            chk("mem_ready", i, 32'(mem_ready), 32'(vecs[i].e_mr));
            @(posedge clk);
            #1;
            chk("we", i, 32'(we), 32'(vecs[i].e_we));
            chk("wa", i, 32'(wa), 32'(vecs[i].e_wa));
            chk("wd", i, wd, vecs[i].e_wd);
            chk("busy", i, 32'(busy), 32'(vecs[i].e_busy));
        end

        // Reset while a write is being driven and a request is pending
        idle_inputs();
        claim_valid = 1'b1;
        claim_addr  = 4'd6;
        @(posedge clk);
        #1;
        chk("mr_busy_pre", 100, 32'(busy), 32'h0040);
        claim_valid = 1'b1;
        claim_addr  = 4'd2;
        alu_valid   = 1'b1;
        alu_addr    = 4'd6;
        alu_data    = 32'h77;
        @(posedge clk);
        #1;
        chk("mr_we_pre", 101, 32'(we), 32'h1);
        chk("mr_wa_pre", 101, 32'(wa), 32'h6);
        chk("mr_busy_mid", 101, 32'(busy), 32'h0004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_we", 102, 32'(we), 32'h0);
        chk("mr_wa", 102, 32'(wa), 32'h0);
        chk("mr_busy", 102, 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        chk("mr_we_hold", 103, 32'(we), 32'h0);
        idle_inputs();
        rst_n = 1'b1;
        // Requester re-presents after reset and is written normally
        alu_valid = 1'b1;
        alu_addr  = 4'd6;
        alu_data  = 32'h77;
        #1;
        chk("mr_ready", 104, 32'(alu_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("mr_we_post", 104, 32'(we), 32'h1);
        chk("mr_wd_post", 104, wd, 32'h77);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("mr_we_drop", 105, 32'(we), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port (we/wa/wd) between two writeback requesters: the ALU result path and the memory load path.
- Uses valid/ready handshakes, round-robin arbitration on conflict and a registered write-port drive.
- Keeps a per-register pending-write scoreboard. The issue stage sets ("claims") a bit; the bit clears when that register's write is granted. The decoder reads the scoreboard to stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- ADDR_WIDTH, 4, register address width; scoreboard has 1<<ADDR_WIDTH bits.
- DATA_WIDTH, 32, write data width; matches the register file word width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  when 1, no grants are issued this cycle
- alu_valid  input  1  ALU writeback request
- alu_addr  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- alu_ready  output  1  ALU request accepted this cycle (combinational)
- mem_valid  input  1  load writeback request
- mem_addr  input  ADDR_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load data
- mem_ready  output  1  load request accepted this cycle (combinational)
- claim_valid  input  1  issue stage reserves a destination register
- claim_addr  input  ADDR_WIDTH  register being reserved
- we  output  1  register file write enable (registered)
- wa  output  ADDR_WIDTH  register file write address (registered)
- wd  output  DATA_WIDTH  register file write data (registered)
- busy  output  1<<ADDR_WIDTH  pending-write bitmask, bit i = register i (registered)

Behaviour:
- Reset is asynchronous on rst_n low and overrides everything: we=0, wa=0, wd=0, busy=0, last_grant=MEM so the ALU wins the first tie.
- alu_ready and mem_ready are combinational from the valids, stall and last_grant. A handshake completes on a rising clk edge where valid&&ready.
- Grant rules:
  - stall=1: both readies 0.
  - Only one valid: that requester is ready.
  - Both valid: the requester not equal to last_grant is ready; the other sees ready=0 and must hold valid/addr/data stable.
  - At most one ready is ever high.
- last_grant updates only on a completed handshake.
- Write port, on each edge:
  - Grant: we<=1, wa<=granted addr, wd<=granted data.
  - No grant: we<=0; wa and wd hold.
  - Back-to-back grants give we high on consecutive cycles.
- Latency:
  - Handshake edge N gives we/wa/wd valid in cycle N+1.
  - The register file commits at edge N+1.
  - The new value appears on the register file read outputs after edge N+2, since its reads are registered.
- Scoreboard, per edge:
  - Clear: busy[granted addr]<=0 at the grant edge.
  - Set: busy[claim_addr]<=1 when claim_valid=1.
  - Same address cleared and claimed on the same edge: set wins, so the bit stays 1 for the new producer.
  - Different addresses: both take effect.
- No claim/grant counting per register: a second claim of an already-busy register keeps the bit at 1, and the first grant clears it. Issue logic must not claim a busy register; the block does not check this.
- Requests to an unclaimed register are legal: they are written normally, and busy stays 0.
- Reset mid-transaction: a pending request or a write being driven is dropped (we=0 immediately). Requesters re-present after reset.
- No combinational path from any input to we/wa/wd/busy.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with alu_valid=1 -> we=0, busy=0 immediately. Release, then alu_valid=1, alu_addr=3, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle we=1, wa=3, wd=0xDEADBEEF; following cycle we=0.
- Tie round-robin: both valid for 4 cycles (alu addr 1, mem addr 2, requesters re-present after each accept) -> grant order ALU, MEM, ALU, MEM; wa sequence 1, 2, 1, 2; the losing ready is 0 in each cycle.
- Stall: both valid, stall=1 for 3 cycles -> both readies 0, we=0. Drop stall -> ALU granted first (last_grant=MEM after reset).
- Scoreboard: claim r5 -> busy=0x0020 next cycle. mem write r5 granted -> busy=0x0000 after the grant edge. Claim r7 and grant r5 on the same edge -> busy=0x0080.
- Set-wins collision: busy[4]=1, then on one edge ALU write r4 is granted and claim_addr=4 -> busy[4] stays 1; we=1, wa=4 next cycle.
- Unclaimed write: mem write r9 with busy=0 -> we=1, wa=9; busy stays 0x0000.
